// File: rtl/dma_ahb_master_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dma_ahb_master_seq                                         |
// | Description : AHB-Lite master sequencer for the DMA. On an arbiter grant  |
// |               it latches the selected stream's request and runs one       |
// |               fixed-length burst (SINGLE/INCR4/8/16) with overlapped      |
// |               address and data phases, reporting per-beat, per-burst and  |
// |               error completion back to the stream logic.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   i_clk, i_nreset        clock, asynchronous active-low reset             |
// |   i_master_en            grant; starts a burst when sampled in IDLE       |
// |   i_stream_sel           granted stream                                   |
// |   i_addr/size/burst/     per-stream request fields                        |
// |   i_write/i_wdata                                                         |
// |   o_master_ready         high only in IDLE                                |
// |   o_beat_done/o_burst_done/o_error  one-cycle completion pulses           |
// |   o_beat_stream          stream owning the current burst                  |
// |   o_next_addr            address after last completed beat               |
// |   o_rdata/o_rdata_valid  captured read data                               |
// |   o_h*, i_h*             AHB-Lite master interface                        |
// +--------------------------------------------------------------------------+
module dma_ahb_master_seq #(
   parameter int numb_ch = 1,
   localparam int SW = (numb_ch > 1) ? $clog2(numb_ch) : 1
) (
   input  logic            i_clk,
   input  logic            i_nreset,
   input  logic            i_master_en,
   input  logic [SW-1:0]   i_stream_sel,
   input  logic [31:0]     i_addr  [numb_ch],
   input  logic [1:0]      i_size  [numb_ch],
   input  logic [1:0]      i_burst [numb_ch],
   input  logic            i_write [numb_ch],
   input  logic [31:0]     i_wdata [numb_ch],
   output logic            o_master_ready,
   output logic            o_beat_done,
   output logic [SW-1:0]   o_beat_stream,
   output logic            o_burst_done,
   output logic            o_error,
   output logic [31:0]     o_next_addr,
   output logic [31:0]     o_rdata,
   output logic            o_rdata_valid,
   output logic [31:0]     o_haddr,
   output logic [1:0]      o_htrans,
   output logic            o_hwrite,
   output logic [2:0]      o_hsize,
   output logic [2:0]      o_hburst,
   output logic [3:0]      o_hprot,
   output logic [31:0]     o_hwdata,
   input  logic            i_hready,
   input  logic            i_hresp,
   input  logic [31:0]     i_hrdata
);

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_LAST = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] stream, stream_nxt;
   logic [31:0]   haddr, haddr_nxt;
   logic [31:0]   dp_addr, dp_addr_nxt;     // address of the beat in data phase
   logic [31:0]   hwdata, hwdata_nxt;
   logic [31:0]   rdata, rdata_nxt;
   logic [31:0]   next_addr, next_addr_nxt;
   logic [1:0]    htrans, htrans_nxt;
   logic [2:0]    hsize, hsize_nxt;
   logic [2:0]    hburst, hburst_nxt;
   logic          hwrite, hwrite_nxt;
   logic [3:0]    addr_left, addr_left_nxt; // address phases still to issue after the current one
   logic          dp, dp_nxt;               // a data phase is in progress
   logic          beat_done, beat_done_nxt;
   logic          burst_done, burst_done_nxt;
   logic          error, error_nxt;
   logic          rdata_valid, rdata_valid_nxt;

   // Decode of the request currently presented by the arbiter.
   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic [4:0]    req_beats;
   logic [6:0]    req_span;
   logic [11:0]   req_end;
   logic          req_split;
   logic          req_aligned;
   logic [2:0]    req_hburst;
   logic [31:0]   step;

   assign step = 32'd1 << hsize[1:0];

   always_comb begin
      req_addr = i_addr[i_stream_sel];
      req_size = (i_size[i_stream_sel] == 2'd3) ? 2'd2 : i_size[i_stream_sel];
      case (i_burst[i_stream_sel])
         2'd0:    begin req_beats = 5'd1;  req_hburst = 3'b000; end
         2'd1:    begin req_beats = 5'd4;  req_hburst = 3'b011; end
         2'd2:    begin req_beats = 5'd8;  req_hburst = 3'b101; end
         default: begin req_beats = 5'd16; req_hburst = 3'b111; end
      endcase
      req_span = 7'(req_beats) << req_size;
      // A burst that would run past a 1KB boundary is issued as SINGLEs.
      req_end   = {2'b00, req_addr[9:0]} + {5'b00000, req_span};
      req_split = (req_end > 12'd1024);
      case (req_size)
         2'd0:    req_aligned = 1'b1;
         2'd1:    req_aligned = ~req_addr[0];
         default: req_aligned = ~|req_addr[1:0];
      endcase
   end

   always_comb begin
      state_nxt       = state;
      stream_nxt      = stream;
      haddr_nxt       = haddr;
      dp_addr_nxt     = dp_addr;
      hwdata_nxt      = hwdata;
      rdata_nxt       = rdata;
      next_addr_nxt   = next_addr;
      htrans_nxt      = htrans;
      hsize_nxt       = hsize;
      hburst_nxt      = hburst;
      hwrite_nxt      = hwrite;
      addr_left_nxt   = addr_left;
      dp_nxt          = dp;
      beat_done_nxt   = 1'b0;
      burst_done_nxt  = 1'b0;
      error_nxt       = 1'b0;
      rdata_valid_nxt = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_master_en) begin
               stream_nxt = i_stream_sel;
               if (!req_aligned) begin
                  error_nxt     = 1'b1;
                  next_addr_nxt = req_addr;
               end else begin
                  state_nxt     = S_BUS;
                  haddr_nxt     = req_addr;
                  htrans_nxt    = HT_NONSEQ;
                  hsize_nxt     = {1'b0, req_size};
                  hburst_nxt    = req_split ? 3'b000 : req_hburst;
                  hwrite_nxt    = i_write[i_stream_sel];
                  addr_left_nxt = 4'(req_beats - 5'd1);
                  dp_nxt        = 1'b0;
               end
            end
         end

         S_BUS, S_LAST: begin
            if (dp && i_hresp) begin
               // Error response: drop any pending address immediately.
               htrans_nxt = HT_IDLE;
               if (i_hready) begin
                  error_nxt     = 1'b1;
                  next_addr_nxt = dp_addr;
                  dp_nxt        = 1'b0;
                  state_nxt     = S_IDLE;
               end else begin
                  state_nxt = S_ERR;
               end
            end else if (i_hready) begin
               if (dp) begin
                  beat_done_nxt = 1'b1;
                  if (!hwrite) begin
                     rdata_nxt       = i_hrdata;
                     rdata_valid_nxt = 1'b1;
                  end
               end
               if (state == S_LAST) begin
                  burst_done_nxt = 1'b1;
                  next_addr_nxt  = dp_addr + step;
                  dp_nxt         = 1'b0;
                  state_nxt      = S_IDLE;
               end else begin
                  // Address phase accepted: it becomes the new data phase.
                  dp_nxt      = 1'b1;
                  dp_addr_nxt = haddr;
                  if (hwrite) begin
                     hwdata_nxt = i_wdata[stream];
                  end
                  if (addr_left == 4'd0) begin
                     htrans_nxt = HT_IDLE;
                     state_nxt  = S_LAST;
                  end else begin
                     haddr_nxt     = haddr + step;
                     htrans_nxt    = (hburst == 3'b000) ? HT_NONSEQ : HT_SEQ;
                     addr_left_nxt = addr_left - 4'd1;
                  end
               end
            end
         end

         S_ERR: begin
            if (i_hready) begin
               error_nxt     = 1'b1;
               next_addr_nxt = dp_addr;
               dp_nxt        = 1'b0;
               state_nxt     = S_IDLE;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         state       <= S_IDLE;
         stream      <= '0;
         haddr       <= '0;
         dp_addr     <= '0;
         hwdata      <= '0;
         rdata       <= '0;
         next_addr   <= '0;
         htrans      <= HT_IDLE;
         hsize       <= '0;
         hburst      <= '0;
         hwrite      <= 1'b0;
         addr_left   <= '0;
         dp          <= 1'b0;
         beat_done   <= 1'b0;
         burst_done  <= 1'b0;
         error       <= 1'b0;
         rdata_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         stream      <= stream_nxt;
         haddr       <= haddr_nxt;
         dp_addr     <= dp_addr_nxt;
         hwdata      <= hwdata_nxt;
         rdata       <= rdata_nxt;
         next_addr   <= next_addr_nxt;
         htrans      <= htrans_nxt;
         hsize       <= hsize_nxt;
         hburst      <= hburst_nxt;
         hwrite      <= hwrite_nxt;
         addr_left   <= addr_left_nxt;
         dp          <= dp_nxt;
         beat_done   <= beat_done_nxt;
         burst_done  <= burst_done_nxt;
         error       <= error_nxt;
         rdata_valid <= rdata_valid_nxt;
      end
   end

   assign o_master_ready = (state == S_IDLE);
   assign o_beat_done    = beat_done;
   assign o_beat_stream  = stream;
   assign o_burst_done   = burst_done;
   assign o_error        = error;
   assign o_next_addr    = next_addr;
   assign o_rdata        = rdata;
   assign o_rdata_valid  = rdata_valid;
   assign o_haddr        = haddr;
   assign o_htrans       = htrans;
   assign o_hwrite       = hwrite;
   assign o_hsize        = hsize;
   assign o_hburst       = hburst;
   assign o_hprot        = 4'b0011;
   assign o_hwdata       = hwdata;

endmodule
`default_nettype wire

// File: tb/tb_dma_ahb_master_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_dma_ahb_master_seq                                      |
// | Description : Self-checking bench for dma_ahb_master_seq: a table of     |
// |               directed bursts, randomized bursts against a protocol-level |
// |               reference, and reset corner sequences.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_dma_ahb_master_seq;

   localparam int N = 2;

   logic        clk = 1'b0;
   logic        nreset;
   logic        master_en;
   logic [0:0]  sel;
   logic [31:0] addr_a  [N];
   logic [1:0]  size_a  [N];
   logic [1:0]  burst_a [N];
   logic        write_a [N];
   logic [31:0] wdata_a [N];
   logic        hready, hresp;
   logic [31:0] hrdata;

   logic        o_master_ready, o_beat_done, o_burst_done, o_error, o_rdata_valid, o_hwrite;
   logic [0:0]  o_beat_stream;
   logic [31:0] o_next_addr, o_rdata, o_haddr, o_hwdata;
   logic [1:0]  o_htrans;
   logic [2:0]  o_hsize, o_hburst;
   logic [3:0]  o_hprot;

   int total = 0;
   int bad   = 0;
   int waits [16];

   always #5 clk = ~clk;

   dma_ahb_master_seq #(.numb_ch(N)) dut (
      .i_clk(clk), .i_nreset(nreset), .i_master_en(master_en), .i_stream_sel(sel),
      .i_addr(addr_a), .i_size(size_a), .i_burst(burst_a), .i_write(write_a), .i_wdata(wdata_a),
      .o_master_ready(o_master_ready), .o_beat_done(o_beat_done), .o_beat_stream(o_beat_stream),
      .o_burst_done(o_burst_done), .o_error(o_error), .o_next_addr(o_next_addr),
      .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
      .o_haddr(o_haddr), .o_htrans(o_htrans), .o_hwrite(o_hwrite), .o_hsize(o_hsize),
      .o_hburst(o_hburst), .o_hprot(o_hprot), .o_hwdata(o_hwdata),
      .i_hready(hready), .i_hresp(hresp), .i_hrdata(hrdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int step_of(input logic [1:0] sz);
      return 1 << ((sz == 2'd3) ? 2 : int'(sz));
   endfunction

   function automatic int beats_of(input logic [1:0] bu);
      case (bu)
         2'd0:    return 1;
         2'd1:    return 4;
         2'd2:    return 8;
         default: return 16;
      endcase
   endfunction

   task automatic scramble_streams();
      for (int i = 0; i < N; i++) begin
         addr_a[i]  = $urandom;
         size_a[i]  = 2'($urandom);
         burst_a[i] = 2'($urandom);
         write_a[i] = 1'($urandom);
         wdata_a[i] = $urandom;
      end
   endtask

   // Runs one grant from a negedge with the DUT idle. The slave drives wait
   // states from waits[] and an ERROR response on beat err_beat (-1: none).
   // Every cycle the outputs are compared against what an AHB-Lite master
   // must show for this request; counts and the final next address return.
   task automatic run_burst(input int s, input logic [31:0] a, input logic [1:0] sz,
                            input logic [1:0] bu, input logic wr, input int err_beat,
                            output int n_beats, output int n_done, output int n_err,
                            output logic [31:0] last_next, output int lat);
      int stp, bts, abeat, dpb, dwait, errph;
      bit split, aligned, dp_on, busy, cancel, fin;
      bit x_bd, x_bud, x_er, x_rv;
      logic [31:0] x_na, x_rd, x_wd;
      logic [2:0]  x_hb, x_hs;
      stp     = step_of(sz);
      bts     = beats_of(bu);
      split   = ((a % 1024) + 32'(bts * stp)) > 1024;
      aligned = (a % stp) == 0;
      x_hb    = split ? 3'b000 : (bu == 0 ? 3'b000 : bu == 1 ? 3'b011 : bu == 2 ? 3'b101 : 3'b111);
      x_hs    = (sz == 2'd3) ? 3'd2 : {1'b0, sz};
      scramble_streams();
      addr_a[s] = a; size_a[s] = sz; burst_a[s] = bu; write_a[s] = wr;
      sel = 1'(s); master_en = 1'b1; hready = 1'b1; hresp = 1'b0;
      busy = aligned; x_er = !aligned; x_na = a; x_bd = 0; x_bud = 0; x_rv = 0;
      x_rd = '0; x_wd = '0;
      abeat = 0; dpb = 0; dwait = 0; errph = 0; dp_on = 0; cancel = 0; fin = 0;
      n_beats = 0; n_done = 0; n_err = 0; last_next = '0; lat = -1;
      @(negedge clk);
      for (int cyc = 1; cyc < 300 && !fin; cyc++) begin
         chk("beat_done", o_beat_done, x_bd);
         chk("burst_done", o_burst_done, x_bud);
         chk("error", o_error, x_er);
         chk("rdata_valid", o_rdata_valid, x_rv);
         if (x_rv) chk("rdata", o_rdata, x_rd);
         if (x_bud || x_er) begin
            chk("next_addr", o_next_addr, x_na);
            last_next = o_next_addr;
         end
         chk("master_ready", o_master_ready, !busy);
         chk("beat_stream", o_beat_stream, s);
         if (busy && !cancel && abeat < bts) begin
            chk("htrans", o_htrans, (abeat == 0 || split) ? 2'b10 : 2'b11);
            chk("haddr", o_haddr, 32'(a + abeat * stp));
            chk("hburst", o_hburst, x_hb);
            chk("hsize", o_hsize, x_hs);
            chk("hwrite", o_hwrite, wr);
         end else begin
            chk("htrans_idle", o_htrans, 2'b00);
         end
         if (busy && dp_on && wr && errph == 0) chk("hwdata", o_hwdata, x_wd);
         n_beats += int'(o_beat_done);
         n_done  += int'(o_burst_done);
         n_err   += int'(o_error);
         if (o_burst_done) lat = cyc;
         if (!busy) begin
            master_en = 1'b0;
            fin = 1;
         end else begin
            // Request inputs change freely; the DUT must ignore them mid-burst.
            scramble_streams();
            master_en = 1'($urandom);
            sel       = 1'($urandom);
            hrdata    = $urandom;
            hready    = 1'b1;
            hresp     = 1'b0;
            if (dp_on) begin
               if (dpb == err_beat) begin
                  hresp  = 1'b1;
                  hready = (errph == 1);
               end else if (dwait > 0) begin
                  hready = 1'b0;
                  dwait--;
               end
            end
            x_bd = 0; x_bud = 0; x_er = 0; x_rv = 0;
            if (dp_on && hresp) begin
               if (errph == 0) begin
                  errph  = 1;
                  cancel = 1;
               end else begin
                  x_er  = 1;
                  x_na  = 32'(a + dpb * stp);
                  busy  = 0;
                  dp_on = 0;
               end
            end else if (hready) begin
               if (dp_on) begin
                  x_bd  = 1;
                  x_rv  = !wr;
                  x_rd  = hrdata;
                  dp_on = 0;
                  if (dpb == bts - 1) begin
                     x_bud = 1;
                     x_na  = 32'(a + bts * stp);
                     busy  = 0;
                  end
               end
               if (busy && !cancel && abeat < bts) begin
                  dp_on = 1;
                  dpb   = abeat;
                  dwait = waits[abeat];
                  x_wd  = wdata_a[s];
                  abeat++;
               end
            end
            @(negedge clk);
         end
      end
      if (!fin) begin
         chk("burst_timeout", 32'd1, 32'd0);
         master_en = 1'b0;
      end
   endtask

   typedef struct {
      int          s;
      logic [31:0] a;
      logic [1:0]  sz;
      logic [1:0]  bu;
      logic        wr;
      int          wb;      // beat with wait states (-1: none)
      int          wc;      // number of wait states on that beat
      int          eb;      // beat answered with ERROR (-1: none)
      int          x_beats;
      int          x_err;
      logic [31:0] x_next;
   } vec_t;

   vec_t vt [11];

   initial begin
      int nb, nd, ne, lat, s, eb, stp, bts, xb, xe;
      logic [31:0] nx, a, xn;
      logic [1:0]  sz, bu;
      logic        wr;
      bit          al;

      vt[0]  = '{0, 32'h0000_0100, 2'd2, 2'd0, 1'b1, -1, 0, -1,  1, 0, 32'h0000_0104};
      vt[1]  = '{1, 32'h0000_2000, 2'd1, 2'd1, 1'b0,  1, 2, -1,  4, 0, 32'h0000_2008};
      vt[2]  = '{0, 32'h0000_03F0, 2'd2, 2'd3, 1'b0, -1, 0, -1, 16, 0, 32'h0000_0430};
      vt[3]  = '{0, 32'h0000_0000, 2'd2, 2'd2, 1'b1, -1, 0,  2,  2, 1, 32'h0000_0008};
      vt[4]  = '{1, 32'h0000_0102, 2'd2, 2'd1, 1'b0, -1, 0, -1,  0, 1, 32'h0000_0102};
      vt[5]  = '{1, 32'hFFFF_FFF8, 2'd2, 2'd1, 1'b1, -1, 0, -1,  4, 0, 32'h0000_0008};
      vt[6]  = '{0, 32'h0000_03FB, 2'd0, 2'd2, 1'b0,  3, 1, -1,  8, 0, 32'h0000_0403};
      vt[7]  = '{0, 32'h0000_0040, 2'd3, 2'd1, 1'b0, -1, 0, -1,  4, 0, 32'h0000_0050};
      vt[8]  = '{1, 32'h0000_0031, 2'd1, 2'd1, 1'b1, -1, 0, -1,  0, 1, 32'h0000_0031};
      vt[9]  = '{1, 32'h0000_0500, 2'd2, 2'd0, 1'b0,  0, 2,  0,  0, 1, 32'h0000_0500};
      vt[10] = '{0, 32'h0000_03E0, 2'd1, 2'd3, 1'b1, -1, 0, -1, 16, 0, 32'h0000_0400};

      nreset = 1'b0; master_en = 1'b0; sel = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;
      scramble_streams();
      repeat (3) @(negedge clk);
      chk("rst_htrans", o_htrans, 2'b00);
      chk("rst_ready", o_master_ready, 1'b1);
      chk("rst_haddr", o_haddr, 32'h0);
      chk("rst_hwdata", o_hwdata, 32'h0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_next_addr", o_next_addr, 32'h0);
      chk("rst_pulses", {o_beat_done, o_burst_done, o_error, o_rdata_valid}, 4'h0);
      chk("rst_stream", o_beat_stream, 1'b0);
      chk("rst_ctrl", {o_hburst, o_hsize, o_hwrite}, 7'h0);
      chk("hprot", o_hprot, 4'b0011);
      nreset = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         foreach (waits[b]) waits[b] = 0;
         if (vt[i].wb >= 0) waits[vt[i].wb] = vt[i].wc;
         run_burst(vt[i].s, vt[i].a, vt[i].sz, vt[i].bu, vt[i].wr, vt[i].eb, nb, nd, ne, nx, lat);
         chk($sformatf("v%0d_beats", i), nb, vt[i].x_beats);
         chk($sformatf("v%0d_err", i), ne, vt[i].x_err);
         chk($sformatf("v%0d_done", i), nd, (vt[i].x_err == 0) ? 1 : 0);
         chk($sformatf("v%0d_next", i), nx, vt[i].x_next);
         if (vt[i].x_err == 0 && vt[i].wb < 0)
            chk($sformatf("v%0d_latency", i), lat, vt[i].x_beats + 2);
      end

      for (int k = 0; k < 40; k++) begin
         s   = $urandom_range(0, 1);
         sz  = 2'($urandom);
         bu  = 2'($urandom);
         wr  = 1'($urandom);
         stp = step_of(sz);
         bts = beats_of(bu);
         a   = $urandom;
         if ($urandom_range(0, 1) == 0) a[9:6] = 4'hF;
         if ($urandom_range(0, 4) != 0) a = a & ~32'(stp - 1);
         eb  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, bts - 1) : -1;
         foreach (waits[b]) waits[b] = $urandom_range(0, 2);
         al  = (a % stp) == 0;
         xb  = !al ? 0 : (eb >= 0 ? eb : bts);
         xe  = (!al || eb >= 0) ? 1 : 0;
         xn  = !al ? a : (eb >= 0 ? 32'(a + eb * stp) : 32'(a + bts * stp));
         run_burst(s, a, sz, bu, wr, eb, nb, nd, ne, nx, lat);
         chk("rnd_beats", nb, xb);
         chk("rnd_err", ne, xe);
         chk("rnd_done", nd, 1 - xe);
         chk("rnd_next", nx, xn);
      end

      // Reset in the middle of an INCR16 write.
      @(negedge clk);
      addr_a[0] = 32'h0000_1000; size_a[0] = 2'd2; burst_a[0] = 2'd3; write_a[0] = 1'b1;
      sel = '0; master_en = 1'b1; hready = 1'b1; hresp = 1'b0;
      @(negedge clk);
      master_en = 1'b0;
      chk("mid_htrans_pre", o_htrans, 2'b10);
      repeat (2) @(negedge clk);
      chk("mid_busy_pre", o_master_ready, 1'b0);
      nreset = 1'b0;
      #1;
      chk("mid_rst_htrans", o_htrans, 2'b00);
      chk("mid_rst_ready", o_master_ready, 1'b1);
      chk("mid_rst_haddr", o_haddr, 32'h0);
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      chk("mid_rst_pulses", {o_beat_done, o_burst_done, o_error}, 3'b000);
      chk("mid_rst_idle", o_htrans, 2'b00);
      chk("mid_rst_ready2", o_master_ready, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
